// File: rtl/hex_display_driver.sv
// Multi-digit 7-segment hex display driver: latched data, leading-zero
// suppression, per-digit blink and PWM brightness, registered active-low output.
module hex_display_driver #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int PWM_BITS   = 3
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [PWM_BITS-1:0]     duty,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [4*NUM_DIGITS-1:0] value
);

  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [4*NUM_DIGITS-1:0] data_r;
  logic                    blank_lz_r;
  logic [NUM_DIGITS-1:0]   blink_mask_r;
  logic [BLINK_W-1:0]      blink_cnt_r;
  logic                    blink_phase_r;
  logic [PWM_BITS-1:0]     pwm_cnt_r;
  logic [7*NUM_DIGITS-1:0] hex_r;

  logic [7*NUM_DIGITS-1:0] hex_s;
  logic                    pwm_off_s;
  logic                    upper_zero_s;
  logic                    blank_s;
  logic [3:0]              nib_s;

  // Next HEX image from the current latched state and counters
  always_comb begin
    hex_s        = '1;
    upper_zero_s = 1'b1;
    blank_s      = 1'b0;
    nib_s        = 4'h0;
    pwm_off_s    = (pwm_cnt_r >= duty);
    // Walk from the most significant digit so upper_zero_s covers nibbles i..top
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib_s        = data_r[4*i +: 4];
      upper_zero_s = upper_zero_s & (nib_s == 4'h0);
      blank_s      = pwm_off_s
                   | (blink_mask_r[i] & blink_phase_r)
                   | (blank_lz_r & (i != 0) & upper_zero_s);
      if (blank_s) begin
        hex_s[7*i +: 7] = 7'b1111111;
      end else begin
        hex_s[7*i +: 7] = seg7(nib_s);
      end
    end
  end

  // Latched inputs, blink/PWM counters and registered segment output
  always_ff @(posedge Clock) begin
    if (Reset) begin
      data_r        <= '0;
      blank_lz_r    <= 1'b0;
      blink_mask_r  <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      pwm_cnt_r     <= '0;
      hex_r         <= '1;
    end else begin
      if (load) begin
        data_r       <= data;
        blank_lz_r   <= blank_lz;
        blink_mask_r <= blink_mask;
      end
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r   <= '0;
        blink_phase_r <= ~blink_phase_r;
      end else begin
        blink_cnt_r   <= blink_cnt_r + BLINK_W'(1);
      end
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      hex_r     <= hex_s;
    end
  end

  assign HEX   = hex_r;
  assign value = data_r;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed bench for hex_display_driver (6 digits, BLINK_DIV=4, PWM_BITS=3).
module tb_hex_display_driver;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        load;
  logic [23:0] data;
  logic        blank_lz;
  logic [5:0]  blink_mask;
  logic [2:0]  duty;
  logic [41:0] HEX;
  logic [23:0] value;

  hex_display_driver #(.NUM_DIGITS(6), .BLINK_DIV(4), .PWM_BITS(3)) dut (
    .Clock(Clock), .Reset(Reset), .load(load), .data(data),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .duty(duty),
    .HEX(HEX), .value(value)
  );

  always #5 Clock = ~Clock;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [6:0]  BL = 7'b1111111;
  localparam logic [41:0] ONES = 42'h3FF_FFFF_FFFF;
  localparam logic [41:0] P_A5 = {7'b1000000, 7'b1000000, 7'b1000000,
                                  7'b1000000, 7'b0001000, 7'b0010010};
  localparam logic [41:0] P_A5_LZ = {BL, BL, BL, BL, 7'b0001000, 7'b0010010};
  localparam logic [41:0] P_ZERO_LZ = {BL, BL, BL, BL, BL, 7'b1000000};
  localparam logic [34:0] P_12345 = {7'b1111001, 7'b0100100, 7'b0110000,
                                     7'b0011001, 7'b0010010};

  int checks = 0;
  int passed = 0;

  // Reference state: edges since reset, latched inputs, expected HEX
  int          n = 0;
  logic [23:0] m_data = 24'h0;
  logic        m_lz = 1'b0;
  logic [5:0]  m_mask = 6'h0;
  logic [41:0] exp_hex = ONES;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [41:0] model_hex(input logic [23:0] d, input logic lz,
                                            input logic [5:0] mk, input logic [2:0] dt,
                                            input int k);
    logic [41:0] r;
    logic        up;
    logic        ph;
    int          pw;
    logic [3:0]  nib;
    ph = ((k / 4) % 2) == 1;
    pw = k % 8;
    up = 1'b1;
    r  = ONES;
    for (int i = 5; i >= 0; i--) begin
      nib = d[4*i +: 4];
      up  = up && (nib == 4'h0);
      if ((pw >= int'(dt)) || (mk[i] && ph) || (lz && (i > 0) && up)) r[7*i +: 7] = BL;
      else r[7*i +: 7] = SEG_TAB[nib];
    end
    return r;
  endfunction

  task automatic tick();
    if (Reset) begin
      exp_hex = ONES;
      m_data = 24'h0; m_lz = 1'b0; m_mask = 6'h0;
    end else begin
      exp_hex = model_hex(m_data, m_lz, m_mask, duty, n);
      if (load) begin
        m_data = data; m_lz = blank_lz; m_mask = blink_mask;
      end
    end
    @(posedge Clock);
    #1;
    if (Reset) n = 0;
    else n++;
  endtask

  task automatic do_load(input logic [23:0] d, input logic lz, input logic [5:0] mk);
    load = 1'b1; data = d; blank_lz = lz; blink_mask = mk;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [2:0] sweep [3];
    logic [23:0] words [3];
    sweep = '{3'd0, 3'd1, 3'd4};
    words = '{24'h012345, 24'h6789AB, 24'hCDEF01};

    Reset = 1'b1; load = 1'b0; data = 24'h0; blank_lz = 1'b0;
    blink_mask = 6'h0; duty = 3'd0;
    tick(); tick();
    check("reset_hex", HEX, ONES);
    check("reset_value", value, 24'h0);
    Reset = 1'b0;
    tick();
    check("post_reset_off", HEX, ONES);

    // Plain digits, PWM gating at pwm_cnt=7
    duty = 3'd7;
    do_load(24'h0000A5, 1'b0, 6'h00);
    check("load_value", value, 24'h0000A5);
    tick();
    check("a5_lit", HEX, P_A5);
    repeat (4) begin tick(); check("a5_model", HEX, exp_hex); end
    tick();
    check("a5_pwm_blank", HEX, ONES);

    // Leading-zero suppression
    do_load(24'h0000A5, 1'b1, 6'h00);
    tick();
    check("lz_a5", HEX, P_A5_LZ);
    do_load(24'h000000, 1'b1, 6'h00);
    tick();
    check("lz_zero", HEX, P_ZERO_LZ);

    // Blink on digit 0
    do_load(24'h123456, 1'b0, 6'b000001);
    tick();
    check("blink_off", HEX, {P_12345, BL});
    repeat (2) begin tick(); check("blink_model", HEX, exp_hex); end
    tick();
    check("blink_on", HEX, {P_12345, 7'b0000010});
    repeat (8) begin tick(); check("blink_model", HEX, exp_hex); end

    // Brightness sweep
    do_load(24'h123456, 1'b0, 6'h00);
    foreach (sweep[j]) begin
      duty = sweep[j];
      cnt = 0;
      repeat (8) begin
        tick();
        if (HEX[6:0] != BL) cnt++;
      end
      check("duty_sweep", cnt, sweep[j]);
    end

    // All 16 nibble codes
    duty = 3'd7;
    foreach (words[j]) begin
      do_load(words[j], 1'b0, 6'h00);
      repeat (3) begin tick(); check("nibble_map", HEX, exp_hex); end
    end

    // Load coincident with a blink wrap
    do_load(24'h000777, 1'b0, 6'h00);
    while ((n % 4) != 3) tick();
    do_load(24'h000008, 1'b0, 6'b000001);
    repeat (5) begin tick(); check("wrap_load", HEX, exp_hex); end
    check("wrap_value", value, 24'h000008);

    // Reset mid-period overrides a simultaneous load
    tick();
    Reset = 1'b1;
    do_load(24'hFFFFFF, 1'b1, 6'h3F);
    check("reset_load_value", value, 24'h0);
    check("reset_load_hex", HEX, ONES);
    Reset = 1'b0;
    do_load(24'hFFFFFF, 1'b0, 6'h00);
    check("after_reset_load", value, 24'hFFFFFF);
    repeat (10) begin tick(); check("restart_model", HEX, exp_hex); end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
